// File: rtl/sisc_ctrl_fsm.sv
// SISC multi-cycle control FSM: START0/START1/FETCH/DECODE/EXECUTE/MEM/WB/HALT.
// Ports: clk, rst_f, stall, opcode/mm/stat in; PC/IR/RF/ALU/DM strobes, halted, instr_cnt out.
module sisc_ctrl_fsm #(
  parameter int OP_W     = 4,
  parameter int MM_W     = 4,
  parameter int STAT_W   = 4,
  parameter int IMM_MODE = 8,
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              stall,
  input  logic [OP_W-1:0]   opcode,
  input  logic [MM_W-1:0]   mm,
  input  logic [STAT_W-1:0] stat,
  output logic              pc_rst,
  output logic              pc_write,
  output logic              pc_sel,
  output logic              br_sel,
  output logic              ir_load,
  output logic              rb_sel,
  output logic [1:0]        alu_op,
  output logic              rf_we,
  output logic              wb_sel,
  output logic              dm_we,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [2:0] {
    S_START0,
    S_START1,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_LOD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_STR = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SWP = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BRA = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BRR = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BNR = OP_W'(7);
  localparam logic [OP_W-1:0] OP_ALU = OP_W'(8);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

  localparam logic [MM_W-1:0] IMM_VAL  = MM_W'(IMM_MODE);
  localparam logic [7:0]      WAIT_END = 8'(MEM_WAIT);

  state_t     state;
  state_t     state_nx;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nx;
  logic       cnt_inc;

  logic is_lod, is_str, is_swp, is_alu, is_hlt;
  logic is_bra, is_brr, is_bne, is_bnr;
  logic imm, hit, taken, is_rel, mem_last, busy;

  assign is_lod = (opcode == OP_LOD);
  assign is_str = (opcode == OP_STR);
  assign is_swp = (opcode == OP_SWP);
  assign is_alu = (opcode == OP_ALU);
  assign is_hlt = (opcode == OP_HLT);
  assign is_bra = (opcode == OP_BRA);
  assign is_brr = (opcode == OP_BRR);
  assign is_bne = (opcode == OP_BNE);
  assign is_bnr = (opcode == OP_BNR);

  assign imm      = (mm == IMM_VAL);
  assign hit      = |(mm & stat);
  assign taken    = ((is_bra | is_brr) & hit)
                  | ((is_bne | is_bnr) & ~hit);
  assign is_rel   = is_brr | is_bnr;
  assign mem_last = (wait_cnt == WAIT_END);

  // stall only applies to the instruction-cycle states
  assign busy = (state == S_FETCH) || (state == S_DECODE)
             || (state == S_EXECUTE) || (state == S_MEM)
             || (state == S_WB);

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state     <= S_START0;
      wait_cnt  <= '0;
      instr_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      if (cnt_inc && (instr_cnt != {CNT_W{1'b1}}))
        instr_cnt <= instr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    cnt_inc  = 1'b0;
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    ir_load  = 1'b0;
    rb_sel   = 1'b0;
    alu_op   = 2'b00;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    dm_we    = 1'b0;
    halted   = 1'b0;

    unique case (state)
      S_START0: begin
        pc_rst   = 1'b1;
        state_nx = S_START1;
      end
      S_START1: state_nx = S_FETCH;
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = is_rel;
        end
        state_nx = is_hlt ? S_HALT : S_EXECUTE;
      end
      S_EXECUTE: begin
        unique case (1'b1)
          is_alu:          alu_op = imm ? 2'b01 : 2'b00;
          is_lod, is_str:  alu_op = imm ? 2'b11 : 2'b10;
          default:         alu_op = 2'b00;
        endcase
        rb_sel   = is_str;
        wait_nx  = '0;
        state_nx = S_MEM;
      end
      S_MEM: begin
        if (mem_last) begin
          dm_we    = is_str;
          state_nx = S_WB;
        end else begin
          wait_nx = wait_cnt + 8'd1;
        end
      end
      S_WB: begin
        rf_we    = is_alu | is_lod | is_swp;
        wb_sel   = is_lod;
        cnt_inc  = 1'b1;
        state_nx = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nx = S_START0;
    endcase

    // freeze progress and suppress write strobes; selects stay valid
    if (stall && busy) begin
      state_nx = state;
      wait_nx  = wait_cnt;
      cnt_inc  = 1'b0;
      ir_load  = 1'b0;
      pc_write = 1'b0;
      rf_we    = 1'b0;
      dm_we    = 1'b0;
    end
  end

endmodule
